pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  5-stage (IF/ID/EX/MEM/WB) successor to the single-cycle RV64 decoder.
//  - Decodes the ID-stage instruction.
//  - Carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
//  - Detects RAW/load-use hazards, generates forwarding selects and resolves branch flushes.
//  - Sits beside the datapath pipeline registers; the datapath consumes the staged controls.
// PARAMETERS
//  REG_ADDR_W   5  register index width
//  SUPPORT_JAL  1  1: decode jal (1101111); 0: jal treated as illegal/NOP
//  FWD_EN       1  1: forwarding + load-use stall; 0: no forwarding, stall on any RAW
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           async active-low reset
//  id_instr      in   32          instruction in IF/ID register
//  id_valid      in   1           IF/ID holds a real instruction
//  ex_zero       in   1           ALU zero flag of the instruction in EX
//  stall_i       in   1           external freeze (memory wait)
//  pc_write      out  1           PC may update
//  ifid_write    out  1           IF/ID may load
//  ifid_flush    out  1           IF/ID loads a bubble next edge
//  pc_src        out  1           1: PC <= branch/jump target from EX
//  ex_alu_src    out  1           staged ALUSrc (EX)
//  ex_alu_op     out  2           staged ALUOp (EX)
//  ex_jump       out  1           staged jal (EX)
//  fwd_a, fwd_b  out  2           00 regfile, 10 EX/MEM, 01 MEM/WB
//  mem_read      out  1           staged MemRead (MEM)
//  mem_write     out  1           staged MemWrite (MEM)
//  wb_reg_write  out  1           staged RegWrite (WB)
//  wb_mem_to_reg out  1           staged MemtoReg (WB)
//  wb_rd         out  REG_ADDR_W  destination register (WB)
//  illegal       out  1           comb: valid ID opcode not decodable
// BEHAVIOUR
//  Decode (comb, ID):
//  - 0110011 R: RegWrite, ALUOp 10. Uses rs1 and rs2.
//  - 0010011 addi: RegWrite, ALUSrc, ALUOp 00. Uses rs1.
//  - 0000011 ld: RegWrite, ALUSrc, MemRead, MemtoReg. Uses rs1.
//  - 0100011 sd: ALUSrc, MemWrite. Uses rs1 and rs2.
//  - 1100011 beq: Branch, ALUOp 01. Uses rs1 and rs2.
//  - 1101111 jal (if SUPPORT_JAL): RegWrite, Jump. Uses no source registers.
//  - Any other opcode, or id_valid=0: all controls 0 (bubble). illegal=id_valid & undecodable.
//  - rd=x0: RegWrite forced to 0.
//  Pipeline registers:
//  - Each stage holds a valid bit and its control subset plus rd.
//  - All advance on each edge unless stall_i=1; then every stage register, PC and IF/ID hold.
//  - While stall_i=1: pc_write=0 and ifid_write=0.
//  Hazards (evaluated in ID, comb):
//  - FWD_EN=1: hz = ex.MemRead & ex.rd!=0 & (ex.rd==rs1 | (uses_rs2 & ex.rd==rs2)).
//  - FWD_EN=0: hz = any EX or MEM stage with RegWrite & rd!=0 matching a used rs.
//    WB is excluded because the regfile is write-before-read.
//  - hz: pc_write=0, ifid_write=0, and ID/EX loads a bubble.
//    Load-use latency is 1 bubble with FWD_EN=1; up to 2 bubbles with FWD_EN=0.
//  Forwarding (FWD_EN=1, EX stage): EX/MEM match has priority over MEM/WB; rd=0 never forwards.
//  - With FWD_EN=0: fwd_a=fwd_b=00.
//  Control transfer:
//  - pc_src = ex.valid & (ex.Branch & ex_zero | ex.Jump).
//  - When pc_src=1: ifid_flush=1 and ID/EX loads a bubble on the same edge.
//  - pc_src overrides hz, so pc_write=1 that cycle.
//  - Branch penalty is 2 cycles.
//  Priority: stall_i > pc_src > hz.
//  Reset (async, rst_n=0): all stage valids and controls clear to 0, wb_rd=0.
//  - Outputs: pc_write=1, ifid_write=1, ifid_flush=0, pc_src=0, fwd_*=00.
//  - Reset mid-operation discards all in-flight instructions.
// TESTING
//  1. add x3,x1,x2 then sub x4,x3,x1 (FWD_EN=1) -> fwd_a=10 for sub in EX; no stall.
//  2. ld x5,0(x1) then add x6,x5,x2 -> 1 cycle pc_write=0,ifid_write=0, bubble in EX; then fwd_a=01.
//  3. beq in EX with ex_zero=1 -> pc_src=1, ifid_flush=1, next EX bubble; ex_zero=0 -> no flush.
//  4. FWD_EN=0: addi x7,x0,1 then add x8,x7,x7 -> 2 stall cycles; fwd_* stay 00.
//  5. Opcode 7'h7F valid -> illegal=1, bubble propagates; add with rd=x0 -> wb_reg_write=0.
//  6. stall_i=1 for 3 cycles mid-stream -> all stages frozen; rst_n low mid-run -> all controls 0 asynchronously.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Control path for a 5-stage RV64 subset pipeline (IF/ID/EX/MEM/WB).
// Decodes the ID instruction, carries the control bundle through the
// ID/EX, EX/MEM and MEM/WB registers, detects data hazards, drives the
// forwarding muxes and resolves branch/jump flushes in EX.
module pipelined_control_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter bit SUPPORT_JAL = 1'b1,
  parameter bit FWD_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           id_instr,
  input  logic                  id_valid,
  input  logic                  ex_zero,
  input  logic                  stall_i,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  pc_src,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_jump,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  illegal
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Full bundle held in ID/EX; rs fields and use flags feed the forwarding unit.
  typedef struct packed {
    logic                  vld;
    logic                  reg_write;
    logic                  alu_src;
    logic [1:0]            alu_op;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  branch;
    logic                  jump;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } idex_t;

  typedef struct packed {
    logic                  vld;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic                  vld;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } memwb_t;

  idex_t  w_dec;
  logic   w_ok;
  logic   w_hz;
  logic   w_pc_src;
  idex_t  r_ex;
  exmem_t r_mem;
  memwb_t r_wb;
  logic   w_unused;

  // True when a writer with destination rd feeds a source the ID instruction reads.
  function automatic logic f_raw(input logic we, input logic [REG_ADDR_W-1:0] rd,
                                 input idex_t d);
    f_raw = we && (rd != '0) &&
            ((d.use_rs1 && rd == d.rs1) || (d.use_rs2 && rd == d.rs2));
  endfunction

  // Forward select for one EX operand; the younger EX/MEM result wins.
  function automatic logic [1:0] f_fwd(input logic use_rs, input logic [REG_ADDR_W-1:0] rs,
                                       input exmem_t m, input memwb_t w);
    f_fwd = 2'b00;
    if (use_rs && m.reg_write && m.rd != '0 && m.rd == rs)
      f_fwd = 2'b10;
    else if (use_rs && w.reg_write && w.rd != '0 && w.rd == rs)
      f_fwd = 2'b01;
  endfunction

  // ID decode; anything not decodable or not valid becomes an all-zero bubble.
  always_comb begin
    w_dec = '0;
    w_ok  = 1'b1;
    unique case (id_instr[6:0])
      OP_R:    begin w_dec.reg_write = 1'b1; w_dec.alu_op = 2'b10;
                     w_dec.use_rs1 = 1'b1; w_dec.use_rs2 = 1'b1; end
      OP_ADDI: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1;
                     w_dec.use_rs1 = 1'b1; end
      OP_LD:   begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1;
                     w_dec.mem_read = 1'b1; w_dec.mem_to_reg = 1'b1;
                     w_dec.use_rs1 = 1'b1; end
      OP_SD:   begin w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1;
                     w_dec.use_rs1 = 1'b1; w_dec.use_rs2 = 1'b1; end
      OP_BEQ:  begin w_dec.branch = 1'b1; w_dec.alu_op = 2'b01;
                     w_dec.use_rs1 = 1'b1; w_dec.use_rs2 = 1'b1; end
      OP_JAL:  begin
                 if (SUPPORT_JAL) begin
                   w_dec.reg_write = 1'b1;
                   w_dec.jump      = 1'b1;
                 end else begin
                   w_ok = 1'b0;
                 end
               end
      default: w_ok = 1'b0;
    endcase
    if (!id_valid || !w_ok) begin
      w_dec = '0;
    end else begin
      w_dec.vld = 1'b1;
      w_dec.rd  = id_instr[7  +: REG_ADDR_W];
      w_dec.rs1 = id_instr[15 +: REG_ADDR_W];
      w_dec.rs2 = id_instr[20 +: REG_ADDR_W];
      if (w_dec.rd == '0) w_dec.reg_write = 1'b0;
    end
  end

  assign illegal = id_valid & ~w_ok;

  // With forwarding only a load in EX must wait; without it any pending
  // EX/MEM writer must drain (WB is fine since the regfile writes first).
  assign w_hz = FWD_EN ? f_raw(r_ex.mem_read, r_ex.rd, w_dec)
                       : (f_raw(r_ex.reg_write, r_ex.rd, w_dec) |
                          f_raw(r_mem.reg_write, r_mem.rd, w_dec));

  assign w_pc_src   = r_ex.vld & ((r_ex.branch & ex_zero) | r_ex.jump);
  assign pc_src     = w_pc_src;
  // A taken transfer squashes the hazarding instruction, so it beats hz.
  assign pc_write   = ~stall_i & (w_pc_src | ~w_hz);
  assign ifid_write = ~stall_i & (w_pc_src | ~w_hz);
  assign ifid_flush = ~stall_i & w_pc_src;

  assign fwd_a = FWD_EN ? f_fwd(r_ex.use_rs1, r_ex.rs1, r_mem, r_wb) : 2'b00;
  assign fwd_b = FWD_EN ? f_fwd(r_ex.use_rs2, r_ex.rs2, r_mem, r_wb) : 2'b00;

  // Stage registers: freeze on stall_i, bubble into EX on flush or hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!stall_i) begin
      r_ex  <= (w_pc_src || w_hz) ? '0 : w_dec;
      r_mem <= '{vld: r_ex.vld, reg_write: r_ex.reg_write, mem_read: r_ex.mem_read,
                 mem_write: r_ex.mem_write, mem_to_reg: r_ex.mem_to_reg, rd: r_ex.rd};
      r_wb  <= '{vld: r_mem.vld, reg_write: r_mem.reg_write,
                 mem_to_reg: r_mem.mem_to_reg, rd: r_mem.rd};
    end
  end

  assign ex_alu_src    = r_ex.alu_src;
  assign ex_alu_op     = r_ex.alu_op;
  assign ex_jump       = r_ex.jump;
  assign mem_read      = r_mem.mem_read;
  assign mem_write     = r_mem.mem_write;
  assign wb_reg_write  = r_wb.reg_write;
  assign wb_mem_to_reg = r_wb.mem_to_reg;
  assign wb_rd         = r_wb.rd;

  // funct3/funct7 are the datapath's concern; stage valids are kept for debug.
  assign w_unused = ^{id_instr[31:25], id_instr[14:12], r_mem.vld, r_wb.vld};

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: vector tables for forwarding/no-forwarding streams plus
// hand sequences for external stall and asynchronous reset.
module tb_pipelined_control_unit;

  // Output snapshot: pcw ifw flush pcsrc | asrc | aop | jmp | fa | fb | mr mw rw m2r | rd | ill
  typedef struct packed {
    logic       pcw, ifw, fl, pcs;
    logic       asrc;
    logic [1:0] aop;
    logic       jmp;
    logic [1:0] fa, fb;
    logic       mr, mw, rw, m2r;
    logic [4:0] rd;
    logic       ill;
  } outs_t;

  typedef struct {
    logic [31:0] ins;
    logic        v;
    logic        z;
    outs_t       e;
  } vec_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'h7F;
  localparam outs_t IDLE = 22'b1100_0_00_0_00_00_0000_00000_0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_instr = '0;
  logic        id_valid = 1'b0;
  logic        ex_zero = 1'b0;
  logic        stall_i = 1'b0;

  logic       pcw_f, ifw_f, fl_f, pcs_f, asrc_f, jmp_f, mr_f, mw_f, rw_f, m2r_f, ill_f;
  logic [1:0] aop_f, fa_f, fb_f;
  logic [4:0] rd_f;
  logic       pcw_n, ifw_n, fl_n, pcs_n, asrc_n, jmp_n, mr_n, mw_n, rw_n, m2r_n, ill_n;
  logic [1:0] aop_n, fa_n, fb_n;
  logic [4:0] rd_n;

  outs_t a_f, a_n, act;
  logic  sel_f = 1'b1;
  int    n_chk = 0;
  int    n_fail = 0;
  vec_t  tv_f[$];
  vec_t  tv_n[$];

  always #5 clk = ~clk;

  pipelined_control_unit #(.REG_ADDR_W(5), .SUPPORT_JAL(1'b1), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .ex_zero(ex_zero), .stall_i(stall_i),
    .pc_write(pcw_f), .ifid_write(ifw_f), .ifid_flush(fl_f), .pc_src(pcs_f),
    .ex_alu_src(asrc_f), .ex_alu_op(aop_f), .ex_jump(jmp_f),
    .fwd_a(fa_f), .fwd_b(fb_f), .mem_read(mr_f), .mem_write(mw_f),
    .wb_reg_write(rw_f), .wb_mem_to_reg(m2r_f), .wb_rd(rd_f), .illegal(ill_f)
  );

  pipelined_control_unit #(.REG_ADDR_W(5), .SUPPORT_JAL(1'b1), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .ex_zero(ex_zero), .stall_i(stall_i),
    .pc_write(pcw_n), .ifid_write(ifw_n), .ifid_flush(fl_n), .pc_src(pcs_n),
    .ex_alu_src(asrc_n), .ex_alu_op(aop_n), .ex_jump(jmp_n),
    .fwd_a(fa_n), .fwd_b(fb_n), .mem_read(mr_n), .mem_write(mw_n),
    .wb_reg_write(rw_n), .wb_mem_to_reg(m2r_n), .wb_rd(rd_n), .illegal(ill_n)
  );

  assign a_f = {pcw_f, ifw_f, fl_f, pcs_f, asrc_f, aop_f, jmp_f, fa_f, fb_f,
                mr_f, mw_f, rw_f, m2r_f, rd_f, ill_f};
  assign a_n = {pcw_n, ifw_n, fl_n, pcs_n, asrc_n, aop_n, jmp_n, fa_n, fb_n,
                mr_n, mw_n, rw_n, m2r_n, rd_n, ill_n};
  assign act = sel_f ? a_f : a_n;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic chk(input string nm, input outs_t e);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, e);
    end
  endtask

  // Drive one ID slot just after an edge, check before the next edge, then clock.
  task automatic apply(input string nm, input logic [31:0] ins, input logic v,
                       input logic z, input logic s, input outs_t e);
    id_instr = ins; id_valid = v; ex_zero = z; stall_i = s;
    #3;
    chk(nm, e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input string nm);
    rst_n = 1'b0; id_valid = 1'b0; ex_zero = 1'b0; stall_i = 1'b0; id_instr = '0;
    #3;
    chk(nm, IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Forwarding stream: add->sub fwd, ld-use stall, sd fwd_b, illegal, rd=x0, jal, beq.
    tv_f.push_back('{enc(OP_R,    5'd3,  5'd1, 5'd2), 1'b1, 1'b0, 22'b1100_0_00_0_00_00_0000_00000_0});
    tv_f.push_back('{enc(OP_R,    5'd4,  5'd3, 5'd1), 1'b1, 1'b0, 22'b1100_0_10_0_00_00_0000_00000_0});
    tv_f.push_back('{enc(OP_LD,   5'd5,  5'd1, 5'd0), 1'b1, 1'b0, 22'b1100_0_10_0_10_00_0000_00000_0});
    tv_f.push_back('{enc(OP_R,    5'd6,  5'd5, 5'd2), 1'b1, 1'b0, 22'b0000_1_00_0_00_00_0010_00011_0});
    tv_f.push_back('{enc(OP_R,    5'd6,  5'd5, 5'd2), 1'b1, 1'b0, 22'b1100_0_00_0_00_00_1010_00100_0});
    tv_f.push_back('{enc(OP_SD,   5'd0,  5'd3, 5'd6), 1'b1, 1'b0, 22'b1100_0_10_0_01_00_0011_00101_0});
    tv_f.push_back('{enc(OP_BAD,  5'd0,  5'd0, 5'd0), 1'b1, 1'b0, 22'b1100_1_00_0_00_10_0000_00000_1});
    tv_f.push_back('{enc(OP_R,    5'd0,  5'd1, 5'd2), 1'b1, 1'b0, 22'b1100_0_00_0_00_00_0110_00110_0});
    tv_f.push_back('{enc(OP_JAL,  5'd1,  5'd0, 5'd0), 1'b1, 1'b0, 22'b1100_0_10_0_00_00_0000_00000_0});
    tv_f.push_back('{enc(OP_ADDI, 5'd9,  5'd0, 5'd0), 1'b1, 1'b0, 22'b1111_0_00_1_00_00_0000_00000_0});
    tv_f.push_back('{enc(OP_ADDI, 5'd9,  5'd0, 5'd0), 1'b0, 1'b0, 22'b1100_0_00_0_00_00_0000_00000_0});
    tv_f.push_back('{enc(OP_BAD,  5'd0,  5'd0, 5'd0), 1'b0, 1'b0, 22'b1100_0_00_0_00_00_0010_00001_0});
    tv_f.push_back('{enc(OP_BEQ,  5'd0,  5'd1, 5'd2), 1'b1, 1'b0, 22'b1100_0_00_0_00_00_0000_00000_0});
    tv_f.push_back('{enc(OP_ADDI, 5'd10, 5'd1, 5'd0), 1'b1, 1'b1, 22'b1111_0_01_0_00_00_0000_00000_0});
    tv_f.push_back('{32'h0,                           1'b0, 1'b0, 22'b1100_0_00_0_00_00_0000_00000_0});
    tv_f.push_back('{enc(OP_BEQ,  5'd0,  5'd1, 5'd2), 1'b1, 1'b0, 22'b1100_0_00_0_00_00_0000_00000_0});
    tv_f.push_back('{enc(OP_ADDI, 5'd10, 5'd1, 5'd0), 1'b1, 1'b0, 22'b1100_0_01_0_00_00_0000_00000_0});
    tv_f.push_back('{32'h0,                           1'b0, 1'b0, 22'b1100_1_00_0_00_00_0000_00000_0});
    tv_f.push_back('{32'h0,                           1'b0, 1'b0, 22'b1100_0_00_0_00_00_0000_00000_0});
    tv_f.push_back('{32'h0,                           1'b0, 1'b0, 22'b1100_0_00_0_00_00_0010_01010_0});

    // No-forwarding stream: 2-cycle RAW stall, then taken beq overriding a hazard.
    tv_n.push_back('{enc(OP_ADDI, 5'd7,  5'd0,  5'd0),  1'b1, 1'b0, 22'b1100_0_00_0_00_00_0000_00000_0});
    tv_n.push_back('{enc(OP_R,    5'd8,  5'd7,  5'd7),  1'b1, 1'b0, 22'b0000_1_00_0_00_00_0000_00000_0});
    tv_n.push_back('{enc(OP_R,    5'd8,  5'd7,  5'd7),  1'b1, 1'b0, 22'b0000_0_00_0_00_00_0000_00000_0});
    tv_n.push_back('{enc(OP_R,    5'd8,  5'd7,  5'd7),  1'b1, 1'b0, 22'b1100_0_00_0_00_00_0010_00111_0});
    tv_n.push_back('{enc(OP_ADDI, 5'd11, 5'd0,  5'd0),  1'b1, 1'b0, 22'b1100_0_10_0_00_00_0000_00000_0});
    tv_n.push_back('{enc(OP_BEQ,  5'd0,  5'd0,  5'd0),  1'b1, 1'b0, 22'b1100_1_00_0_00_00_0000_00000_0});
    tv_n.push_back('{enc(OP_R,    5'd12, 5'd11, 5'd11), 1'b1, 1'b1, 22'b1111_0_01_0_00_00_0010_01000_0});
    tv_n.push_back('{32'h0,                             1'b0, 1'b0, 22'b1100_0_00_0_00_00_0010_01011_0});

    sel_f = 1'b1;
    reset_dut("reset_fwd");
    foreach (tv_f[i])
      apply($sformatf("fwd[%0d]", i), tv_f[i].ins, tv_f[i].v, tv_f[i].z, 1'b0, tv_f[i].e);

    sel_f = 1'b0;
    reset_dut("reset_nofwd");
    foreach (tv_n[i])
      apply($sformatf("nofwd[%0d]", i), tv_n[i].ins, tv_n[i].v, tv_n[i].z, 1'b0, tv_n[i].e);

    // External freeze for 3 edges: nothing may move, then resume.
    sel_f = 1'b1;
    reset_dut("reset_stall");
    apply("stl_add", enc(OP_R,  5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 22'b1100_0_00_0_00_00_0000_00000_0);
    apply("stl_sub", enc(OP_R,  5'd4, 5'd3, 5'd1), 1'b1, 1'b0, 1'b0, 22'b1100_0_10_0_00_00_0000_00000_0);
    for (int k = 0; k < 3; k++)
      apply($sformatf("stl_hold%0d", k), enc(OP_LD, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b1,
            22'b0000_0_10_0_10_00_0000_00000_0);
    apply("stl_release", enc(OP_LD, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0, 22'b1100_0_10_0_10_00_0000_00000_0);

    // Load-use hazard pending, then reset drops mid-cycle with no clock edge.
    id_instr = enc(OP_R, 5'd6, 5'd5, 5'd2); id_valid = 1'b1; ex_zero = 1'b0; stall_i = 1'b0;
    #3;
    chk("stl_ldhz", 22'b0000_1_00_0_00_00_0010_00011_0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", IDLE);
    @(posedge clk);
    #1;
    chk("rst_hold", IDLE);
    rst_n = 1'b1;
    id_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst", IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
